// File: rtl/cache_refill_controller.sv
// -----------------------------------------------------------------------------
// cache_refill_controller
//
// Single-word cache refill engine. A CPU lookup that misses in IDLE latches
// the word-aligned address, requests that word from main memory, waits for
// the returned data and writes it into the cache with a one-cycle fill strobe.
// Every accepted miss is counted in a saturating counter.
//
// Ports:
//   clk           clock, all state updates on the rising edge
//   rst_n         asynchronous active-low reset
//   req_i         CPU lookup valid this cycle
//   addr_i        lookup byte address
//   hit_i         cache hit flag for addr_i
//   stall_o       freeze the CPU pipeline (combinational in IDLE)
//   mem_req_o     word read request to main memory
//   mem_addr_o    word-aligned read address (latched miss address)
//   mem_ready_i   memory accepts the request
//   mem_valid_i   mem_rdata_i is valid (only looked at in WAIT)
//   mem_rdata_i   returned word
//   fill_o        one-cycle cache write strobe
//   fill_addr_o   refill address (latched miss address)
//   fill_data_o   refill word
//   miss_count_o  saturating miss counter
// -----------------------------------------------------------------------------
module cache_refill_controller #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic                  hit_i,
  output logic                  stall_o,
  output logic                  mem_req_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  input  logic                  mem_ready_i,
  input  logic                  mem_valid_i,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  output logic                  fill_o,
  output logic [ADDR_WIDTH-1:0] fill_addr_o,
  output logic [DATA_WIDTH-1:0] fill_data_o,
  output logic [CNT_WIDTH-1:0]  miss_count_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_FILL = 2'd3
  } state_e;

  state_e                  state_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic                    mem_req_q;
  logic                    fill_q;
  logic [DATA_WIDTH-1:0]   fill_data_q;
  logic [CNT_WIDTH-1:0]    miss_cnt_q;
  logic [CNT_WIDTH-1:0]    miss_cnt_d;
  logic [ADDR_WIDTH-1:0]   addr_d;
  logic                    miss_w;

  // Refills are whole words, so the byte offset is dropped.
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^addr_i[1:0];

  // Saturating increment: sticks at all-ones instead of wrapping.
  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    if (&v) begin
      return v;
    end
    return v + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  endfunction

  assign miss_w     = (state_q == S_IDLE) && req_i && !hit_i;
  assign addr_d     = {addr_i[ADDR_WIDTH-1:2], 2'b00};
  assign miss_cnt_d = sat_inc(miss_cnt_q);

  // Stall must rise in the miss cycle itself, before the FSM has moved, so it
  // is decoded from the live lookup while IDLE. Under reset the FSM sits in
  // IDLE, so the same decode applies.
  assign stall_o = (state_q != S_IDLE) || (req_i && !hit_i);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      mem_req_q   <= 1'b0;
      fill_q      <= 1'b0;
      fill_data_q <= '0;
      miss_cnt_q  <= '0;
    end else begin
      fill_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (miss_w) begin
            addr_q     <= addr_d;
            miss_cnt_q <= miss_cnt_d;
            mem_req_q  <= 1'b1;
            state_q    <= S_REQ;
          end
        end
        S_REQ: begin
          // mem_valid_i is deliberately not looked at here, even on the
          // handshake edge; data only counts once the request is accepted.
          if (mem_ready_i) begin
            mem_req_q <= 1'b0;
            state_q   <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (mem_valid_i) begin
            fill_data_q <= mem_rdata_i;
            fill_q      <= 1'b1;
            state_q     <= S_FILL;
          end
        end
        S_FILL: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q   <= S_IDLE;
          mem_req_q <= 1'b0;
        end
      endcase
    end
  end

  assign mem_req_o    = mem_req_q;
  assign mem_addr_o   = addr_q;
  assign fill_o       = fill_q;
  assign fill_addr_o  = addr_q;
  assign fill_data_o  = fill_data_q;
  assign miss_count_o = miss_cnt_q;

endmodule

// File: tb/tb_cache_refill_controller.sv
// -----------------------------------------------------------------------------
// tb_cache_refill_controller
//
// Directed bench for cache_refill_controller with a 4-bit miss counter so
// saturation is reachable. Inputs change 1ns after a rising edge; outputs are
// compared 2ns after the edge, well clear of it.
// -----------------------------------------------------------------------------
module tb_cache_refill_controller;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int CW = 4;

  logic          clk;
  logic          rst_n;
  logic          req;
  logic [AW-1:0] addr;
  logic          hit;
  logic          stall;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic          mem_ready;
  logic          mem_valid;
  logic [DW-1:0] mem_rdata;
  logic          fill;
  logic [AW-1:0] fill_addr;
  logic [DW-1:0] fill_data;
  logic [CW-1:0] miss_count;

  int n_total;
  int n_bad;
  int fill_pulses;
  int exp_cnt;

  cache_refill_controller #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .CNT_WIDTH (CW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_i       (req),
    .addr_i      (addr),
    .hit_i       (hit),
    .stall_o     (stall),
    .mem_req_o   (mem_req),
    .mem_addr_o  (mem_addr),
    .mem_ready_i (mem_ready),
    .mem_valid_i (mem_valid),
    .mem_rdata_i (mem_rdata),
    .fill_o      (fill),
    .fill_addr_o (fill_addr),
    .fill_data_o (fill_data),
    .miss_count_o(miss_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance to 1ns after the next rising edge, where inputs may be changed.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle after input changes before comparing.
  task automatic settle();
    #1;
  endtask

  // Zero-wait miss: miss cycle, REQ, WAIT, FILL, back in IDLE.
  task automatic do_miss(input logic [AW-1:0] a, input logic [DW-1:0] d);
    req = 1'b1; hit = 1'b0; addr = a;
    mem_ready = 1'b1; mem_valid = 1'b1; mem_rdata = d;
    tick();                 // -> REQ
    req = 1'b0;
    tick();                 // -> WAIT
    tick();                 // -> FILL
    settle();
    check_val("sat_fill", fill, 1'b1);
    check_val("sat_fill_data", fill_data, d);
    tick();                 // -> IDLE
    mem_valid = 1'b0;
  endtask

  initial begin
    n_total = 0;
    n_bad   = 0;
    fill_pulses = 0;
    rst_n = 1'b0;
    req = 1'b0; hit = 1'b0; addr = '0;
    mem_ready = 1'b0; mem_valid = 1'b0; mem_rdata = '0;

    // ---------------- reset state ----------------
    #2;
    check_val("rst_mem_req", mem_req, 1'b0);
    check_val("rst_fill", fill, 1'b0);
    check_val("rst_mem_addr", mem_addr, 32'h0);
    check_val("rst_fill_addr", fill_addr, 32'h0);
    check_val("rst_fill_data", fill_data, 32'h0);
    check_val("rst_miss_count", miss_count, 4'h0);
    check_val("rst_stall_idle", stall, 1'b0);
    req = 1'b1; hit = 1'b0;
    settle();
    check_val("rst_stall_miss", stall, 1'b1);
    req = 1'b0;
    // Edges under reset must not move the FSM
    tick(); tick();
    check_val("rst_hold_miss_count", miss_count, 4'h0);
    rst_n = 1'b1;

    // ---------------- zero-wait miss ----------------
    req = 1'b1; hit = 1'b0; addr = 32'h0000_1004;
    mem_ready = 1'b1; mem_valid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    settle();
    check_val("zw_stall_miss_cycle", stall, 1'b1);
    check_val("zw_mem_req_miss_cycle", mem_req, 1'b0);
    tick();                                   // edge 1 -> REQ
    req = 1'b0;
    settle();
    check_val("zw_mem_req", mem_req, 1'b1);
    check_val("zw_mem_addr", mem_addr, 32'h0000_1004);
    check_val("zw_stall_req", stall, 1'b1);
    check_val("zw_miss_count", miss_count, 4'h1);
    check_val("zw_fill_e1", fill, 1'b0);
    tick();                                   // edge 2 -> WAIT
    settle();
    check_val("zw_mem_req_wait", mem_req, 1'b0);
    check_val("zw_fill_e2", fill, 1'b0);
    check_val("zw_stall_wait", stall, 1'b1);
    tick();                                   // edge 3 -> FILL
    settle();
    check_val("zw_fill_e3", fill, 1'b1);
    check_val("zw_fill_addr", fill_addr, 32'h0000_1004);
    check_val("zw_fill_data", fill_data, 32'hDEAD_BEEF);
    check_val("zw_stall_fill", stall, 1'b1);
    mem_valid = 1'b0;
    tick();                                   // edge 4 -> IDLE
    settle();
    check_val("zw_fill_e4", fill, 1'b0);
    check_val("zw_stall_idle", stall, 1'b0);
    check_val("zw_mem_addr_hold", mem_addr, 32'h0000_1004);

    // ---------------- unaligned address, wait states ----------------
    // CPU holds the lookup under stall; held req must not re-trigger a miss.
    req = 1'b1; hit = 1'b0; addr = 32'h0000_2007;
    mem_ready = 1'b0; mem_valid = 1'b0; mem_rdata = 32'h1234_5678;
    fill_pulses = 0;
    tick();                                   // -> REQ
    settle();
    check_val("ws_mem_addr", mem_addr, 32'h0000_2004);
    check_val("ws_miss_count", miss_count, 4'h2);
    for (int i = 0; i < 2; i++) begin
      check_val("ws_mem_req_held", mem_req, 1'b1);
      check_val("ws_stall_req", stall, 1'b1);
      if (i == 1) mem_ready = 1'b1;
      tick();
      settle();
      if (fill) fill_pulses++;
    end
    mem_ready = 1'b0;                         // now in WAIT
    for (int i = 0; i < 4; i++) begin
      check_val("ws_stall_wait", stall, 1'b1);
      check_val("ws_mem_req_wait", mem_req, 1'b0);
      check_val("ws_fill_wait", fill, 1'b0);
      if (i == 3) begin
        mem_valid = 1'b1; mem_rdata = 32'hCAFE_F00D;
      end
      tick();
      settle();
      if (fill) fill_pulses++;
    end
    // now in FILL; cache now holds the line, so the held lookup hits next
    check_val("ws_fill", fill, 1'b1);
    check_val("ws_fill_addr", fill_addr, 32'h0000_2004);
    check_val("ws_fill_data", fill_data, 32'hCAFE_F00D);
    check_val("ws_stall_fill", stall, 1'b1);
    mem_valid = 1'b0; hit = 1'b1;
    tick();                                   // -> IDLE
    settle();
    if (fill) fill_pulses++;
    check_val("ws_stall_after_hit", stall, 1'b0);
    check_val("ws_miss_count_after", miss_count, 4'h2);
    check_val("ws_fill_pulses", fill_pulses, 1);

    // ---------------- hits ----------------
    req = 1'b1; hit = 1'b1; addr = 32'h0000_5000;
    for (int i = 0; i < 10; i++) begin
      settle();
      check_val("hit_stall", stall, 1'b0);
      check_val("hit_mem_req", mem_req, 1'b0);
      tick();
    end
    check_val("hit_miss_count", miss_count, 4'h2);
    req = 1'b0; hit = 1'b0;

    // ---------------- reset in WAIT ----------------
    req = 1'b1; hit = 1'b0; addr = 32'h0000_3000;
    mem_ready = 1'b1; mem_valid = 1'b0; mem_rdata = 32'h5555_AAAA;
    tick();                                   // -> REQ
    req = 1'b0;
    tick();                                   // -> WAIT
    mem_ready = 1'b0;
    settle();
    check_val("rw_in_wait_stall", stall, 1'b1);
    check_val("rw_in_wait_count", miss_count, 4'h3);
    rst_n = 1'b0;                             // mid-cycle, no clock edge
    settle();
    check_val("rw_async_stall", stall, 1'b0);
    check_val("rw_async_count", miss_count, 4'h0);
    check_val("rw_async_mem_addr", mem_addr, 32'h0);
    check_val("rw_async_fill", fill, 1'b0);
    tick();
    rst_n = 1'b1;
    mem_valid = 1'b1;
    fill_pulses = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      settle();
      if (fill) fill_pulses++;
      check_val("rw_stall_idle", stall, 1'b0);
    end
    check_val("rw_fill_pulses", fill_pulses, 0);
    check_val("rw_miss_count", miss_count, 4'h0);
    check_val("rw_fill_data", fill_data, 32'h0);
    mem_valid = 1'b0;

    // ---------------- stray valid on the handshake edge ----------------
    req = 1'b1; hit = 1'b0; addr = 32'h0000_4000;
    mem_ready = 1'b1; mem_valid = 1'b0; mem_rdata = 32'h0BAD_0BAD;
    tick();                                   // -> REQ
    req = 1'b0;
    mem_valid = 1'b1;                         // same cycle as the handshake
    tick();                                   // -> WAIT, valid ignored
    mem_valid = 1'b0; mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      settle();
      check_val("sv_fill", fill, 1'b0);
      check_val("sv_stall", stall, 1'b1);
      tick();
    end
    mem_valid = 1'b1; mem_rdata = 32'h7777_1111;
    tick();                                   // -> FILL
    settle();
    check_val("sv_fill_late", fill, 1'b1);
    check_val("sv_fill_data", fill_data, 32'h7777_1111);
    check_val("sv_fill_addr", fill_addr, 32'h0000_4000);
    mem_valid = 1'b0;
    tick();                                   // -> IDLE
    check_val("sv_miss_count", miss_count, 4'h1);

    // ---------------- counter saturation ----------------
    rst_n = 1'b0;
    settle();
    rst_n = 1'b1;
    tick();
    exp_cnt = 0;
    for (int i = 0; i < 17; i++) begin
      do_miss(32'h0001_0000 + 32'(i * 4), 32'hA000_0000 + 32'(i));
      exp_cnt = (exp_cnt < 15) ? exp_cnt + 1 : 15;
      settle();
      check_val("sat_count", miss_count, exp_cnt[CW-1:0]);
    end
    check_val("sat_final", miss_count, 4'hF);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
